// File: rtl/block_li_48_withoutround_pkg.sv
// Shared constants for the 48 kHz L+R / L-R chain and the interpolator state encoding.
package block_li_48_withoutround_pkg;

  localparam int SAMPLE_W   = 18;
  localparam int LI_LOG2_UP = 3;
  localparam int LI_SPACING = 4;

  localparam logic [1:0] LI_IDLE = 2'd0;
  localparam logic [1:0] LI_LOAD = 2'd1;
  localparam logic [1:0] LI_WAIT = 2'd2;
  localparam logic [1:0] LI_EMIT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = LI_IDLE,
    ST_LOAD = LI_LOAD,
    ST_WAIT = LI_WAIT,
    ST_EMIT = LI_EMIT
  } li_state_e;

endpackage

// File: rtl/block_li_48_withoutround_if.sv
// Sample-in / interpolated-sample-out strobe bus of the upsampler.
interface block_li_48_withoutround_if
  import block_li_48_withoutround_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W
);
  logic signed [WIDTH-1:0] LI_in;
  logic                    ready_in;
  logic signed [WIDTH-1:0] LI_out;
  logic                    ready_out;
  logic                    overrun;

  modport master (output LI_in, ready_in, input LI_out, ready_out, overrun);
  modport slave  (input LI_in, ready_in, output LI_out, ready_out, overrun);
endinterface

// File: rtl/block_li_48_withoutround_tick_gen.sv
// Spacing down-counter: after a load, tick is high in the (SPACING-1)-th following cycle.
module li_tick_gen #(
  parameter int SPACING = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(SPACING + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear)
      cnt <= '0;
    else if (load)
      cnt <= CW'(SPACING - 1);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == CW'(1));
endmodule

// File: rtl/block_li_48_withoutround.sv
// Linear-interpolation upsampler: each input strobe yields 2^LOG2_UP truncated
// ramp samples from the previous input to the new one, SPACING clocks apart.
module block_li_48_withoutround
  import block_li_48_withoutround_pkg::*;
#(
  parameter int WIDTH   = SAMPLE_W,
  parameter int LOG2_UP = LI_LOG2_UP,
  parameter int SPACING = LI_SPACING
) (
  input  logic                       clock,
  input  logic                       reset,
  block_li_48_withoutround_if.slave  bus
);
  localparam int AW = WIDTH + LOG2_UP + 1;
  localparam int N  = 1 << LOG2_UP;
  localparam logic [LOG2_UP:0] K_LAST = (LOG2_UP + 1)'(N);

  li_state_e               state;
  logic signed [WIDTH-1:0] prev_r, cur_r;
  logic signed [WIDTH:0]   delta;
  logic signed [AW-1:0]    acc, acc_load, acc_step;
  logic [LOG2_UP:0]        k;
  logic                    tick, tick_load;

  function automatic logic signed [WIDTH-1:0] trunc_out(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] s;
    s = a >>> LOG2_UP;
    return s[WIDTH-1:0];
  endfunction

  // acc carries sample*N, so the output is a plain floor shift of it.
  assign delta    = (WIDTH+1)'(cur_r) - (WIDTH+1)'(prev_r);
  assign acc_load = (AW'(prev_r) <<< LOG2_UP) + AW'(delta);
  assign acc_step = acc + AW'(delta);

  assign tick_load = (state == ST_EMIT) && !bus.ready_in && (k != K_LAST);

  li_tick_gen #(.SPACING(SPACING)) u_tick (
    .clock (clock),
    .reset (reset),
    .load  (tick_load),
    .clear (bus.ready_in),
    .tick  (tick)
  );

  // Outputs are registered on entry to EMIT, so the strobe is visible for the
  // whole EMIT cycle; a new input always wins and restarts the burst.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      prev_r        <= '0;
      cur_r         <= '0;
      acc           <= '0;
      k             <= '0;
      bus.LI_out    <= '0;
      bus.ready_out <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.ready_out <= 1'b0;
      bus.overrun   <= 1'b0;
      if (bus.ready_in) begin
        bus.overrun <= (state != ST_IDLE);
        prev_r      <= cur_r;
        cur_r       <= bus.LI_in;
        state       <= ST_LOAD;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_LOAD: begin
            acc           <= acc_load;
            k             <= (LOG2_UP + 1)'(1);
            bus.LI_out    <= trunc_out(acc_load);
            bus.ready_out <= 1'b1;
            state         <= ST_EMIT;
          end
          ST_EMIT: begin
            if (k == K_LAST) begin
              state <= ST_IDLE;
            end else begin
              acc <= acc_step;
              k   <= k + 1'b1;
              if (SPACING == 1) begin
                bus.LI_out    <= trunc_out(acc_step);
                bus.ready_out <= 1'b1;
              end else begin
                state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (tick) begin
              bus.LI_out    <= trunc_out(acc);
              bus.ready_out <= 1'b1;
              state         <= ST_EMIT;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_block_li_48_withoutround.sv
// Directed bench for the interpolating upsampler: ramps, truncation, full scale,
// overrun restart and reset mid-burst, against hand-computed values.
module tb_block_li_48_withoutround;
  import block_li_48_withoutround_pkg::*;

  localparam int SP = LI_SPACING;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_q[8];

  block_li_48_withoutround_if #(.WIDTH(SAMPLE_W)) bus ();

  block_li_48_withoutround #(
    .WIDTH(SAMPLE_W), .LOG2_UP(LI_LOG2_UP), .SPACING(LI_SPACING)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.ready_in = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic send(input logic signed [SAMPLE_W-1:0] x);
    bus.ready_in = 1'b1; bus.LI_in = x;
    step();
    bus.ready_in = 1'b0;
  endtask

  // Cycle t (relative to the ready_in cycle) runs from..to; strobes at t = 2 + j*SP.
  task automatic watch(input int from, input int to);
    bit strobe;
    for (int t = from; t <= to; t++) begin
      @(negedge clock);
      strobe = (t >= 2) && ((t - 2) % SP == 0) && ((t - 2) / SP < 8);
      check($sformatf("ready_out t=%0d", t), bus.ready_out, strobe);
      if (strobe) check($sformatf("LI_out k=%0d", (t - 2) / SP + 1), bus.LI_out, exp_q[(t - 2) / SP]);
      check("overrun", bus.overrun, 0);
      step();
    end
  endtask

  task automatic burst(input logic signed [SAMPLE_W-1:0] x);
    send(x);
    watch(1, 32);
    @(negedge clock);
    check("LI_out hold", bus.LI_out, exp_q[7]);
    check("ready_out idle", bus.ready_out, 0);
    step();
  endtask

  initial begin
    bus.ready_in = 1'b0;
    bus.LI_in    = '0;
    step(); step();
    // reset wins over a simultaneous ready_in
    bus.ready_in = 1'b1; bus.LI_in = 18'sd500;
    step();
    bus.ready_in = 1'b0; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("reset ready_out", bus.ready_out, 0);
      check("reset LI_out", bus.LI_out, 0);
      check("reset overrun", bus.overrun, 0);
      step();
    end

    // 1-2: up and down ramps
    exp_q = '{100, 200, 300, 400, 500, 600, 700, 800};
    burst(18'sd800);
    exp_q = '{700, 600, 500, 400, 300, 200, 100, 0};
    burst(18'sd0);

    // 3: truncation toward minus infinity
    exp_q = '{1, 3, 5, 7, 9, 11, 13, 15};
    burst(18'sd15);
    do_reset();
    exp_q = '{-1, -1, -1, -1, -1, -1, -1, -1};
    burst(-18'sd1);

    // 4: full scale both directions
    do_reset();
    exp_q = '{-16384, -32768, -49152, -65536, -81920, -98304, -114688, -131072};
    burst(-18'sd131072);
    exp_q = '{-98305, -65537, -32769, -1, 32767, 65535, 98303, 131071};
    burst(18'sd131071);
    exp_q = '{98303, 65535, 32767, -1, -32769, -65537, -98305, -131072};
    burst(-18'sd131072);

    // 5: overrun at c+10 restarts from the last input sample
    do_reset();
    exp_q = '{100, 200, 300, 400, 500, 600, 700, 800};
    send(18'sd800);
    watch(1, 9);
    bus.ready_in = 1'b1; bus.LI_in = 18'sd1600;
    @(negedge clock);
    check("pre-abort LI_out", bus.LI_out, 300);
    check("pre-abort ready_out", bus.ready_out, 1);
    step();
    bus.ready_in = 1'b0;
    @(negedge clock);
    check("overrun pulse", bus.overrun, 1);
    check("abort no strobe", bus.ready_out, 0);
    step();
    exp_q = '{900, 1000, 1100, 1200, 1300, 1400, 1500, 1600};
    watch(2, 32);

    // 6: reset mid-burst, then ramp from zero
    do_reset();
    exp_q = '{100, 200, 300, 400, 500, 600, 700, 800};
    send(18'sd800);
    watch(1, 9);
    reset = 1'b1;
    @(negedge clock);
    check("pre-reset LI_out", bus.LI_out, 300);
    step();
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clock);
      check("post-reset ready_out", bus.ready_out, 0);
      check("post-reset LI_out", bus.LI_out, 0);
      step();
    end
    exp_q = '{10, 20, 30, 40, 50, 60, 70, 80};
    burst(18'sd80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
